// File: rtl/axis_frame_trunc.sv
// AXI4-Stream frame length limiter: cuts frames at length_max bytes (tuser[0]=1 on the cut beat), drops the remainder.
// Latency: one cycle, input accept to m_axis_tvalid, through a single output register.
// Backpressure: s_axis_tready follows the output register when passing; forced high while discarding a frame tail.
// Optional: define AXIS_FRAME_TRUNC_STATS_EN for stat_frames/stat_trunc counters with stat_clear.
module axis_frame_trunc #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic [LEN_WIDTH-1:0]  length_max,
    output logic                  status_truncated
`ifdef AXIS_FRAME_TRUNC_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_trunc,
    input  logic                  stat_clear
`endif
);

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [LEN_WIDTH-1:0]   byte_cnt, cnt_nxt;
    logic [LEN_WIDTH-1:0]   lim_reg, lim_nxt;
    logic [LEN_WIDTH-1:0]   lim;
    logic [LEN_WIDTH-1:0]   beat_bytes;
    logic [LEN_WIDTH-1:0]   rem;
    logic [LEN_WIDTH:0]     sum;
    logic                   first_beat;
    logic                   over;
    logic                   accept;
    logic                   load;
    logic                   trunc;
    logic [KEEP_WIDTH-1:0]  trunc_keep;
    logic [KEEP_WIDTH-1:0]  out_keep;
    logic                   out_last;
    logic [USER_WIDTH-1:0]  out_user;

    assign s_axis_tready = (state == DROP) || m_axis_tready || !m_axis_tvalid;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // The limit in force for a frame is taken from length_max on its first beat only.
    assign first_beat = (state == PASS) && (byte_cnt == '0);
    assign lim        = first_beat ? length_max : lim_reg;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + {{(LEN_WIDTH-1){1'b0}}, s_axis_tkeep[i]};
        end
    end

    assign sum  = {1'b0, byte_cnt} + {1'b0, beat_bytes};
    assign over = (lim != '0) && (sum > {1'b0, lim});
    assign rem  = lim - byte_cnt;

    // Thermometer mask keeping exactly the bytes still allowed; rem < KEEP_WIDTH whenever over is set.
    always_comb begin
        trunc_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            trunc_keep[i] = (LEN_WIDTH'(i) < rem);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        lim_nxt   = lim_reg;
        load      = 1'b0;
        trunc     = 1'b0;
        out_keep  = s_axis_tkeep;
        out_last  = s_axis_tlast;
        out_user  = s_axis_tuser;
        case (state)
            PASS: begin
                if (accept) begin
                    load = 1'b1;
                    if (first_beat) begin
                        lim_nxt = length_max;
                    end
                    if (over) begin
                        trunc       = 1'b1;
                        out_keep    = trunc_keep;
                        out_last    = 1'b1;
                        out_user[0] = 1'b1;
                        cnt_nxt     = '0;
                        if (!s_axis_tlast) begin
                            state_nxt = DROP;
                        end
                    end else if (s_axis_tlast) begin
                        cnt_nxt = '0;
                    end else if (sum[LEN_WIDTH]) begin
                        cnt_nxt = '1;
                    end else begin
                        cnt_nxt = sum[LEN_WIDTH-1:0];
                    end
                end
            end
            DROP: begin
                if (accept && s_axis_tlast) begin
                    state_nxt = PASS;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= PASS;
            byte_cnt         <= '0;
            lim_reg          <= '0;
            m_axis_tvalid    <= 1'b0;
            status_truncated <= 1'b0;
        end else begin
            state            <= state_nxt;
            byte_cnt         <= cnt_nxt;
            lim_reg          <= lim_nxt;
            status_truncated <= trunc;
            if (load) begin
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tkeep <= out_keep;
            m_axis_tlast <= out_last;
            m_axis_tuser <= out_user;
        end
    end

`ifdef AXIS_FRAME_TRUNC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_trunc  <= '0;
        end else if (stat_clear) begin
            stat_frames <= '0;
            stat_trunc  <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                stat_frames <= stat_frames + 32'd1;
            end
            if (trunc) begin
                stat_trunc <= stat_trunc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_trunc.sv
// Directed bench for axis_frame_trunc with hand-computed expectations (64-bit data, 8-byte tkeep).
module tb_axis_frame_trunc;

    logic        clk;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [0:0]  s_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic [15:0] length_max;
    logic        status_truncated;

    int nvec = 0;
    int nerr = 0;

    axis_frame_trunc dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tlast     (m_tlast),
        .m_axis_tuser     (m_tuser),
        .length_max       (length_max),
        .status_truncated (status_truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = 1'b0;
        s_tvalid = 1'b1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] d, input logic [7:0] k,
                              input logic l, input logic u, input logic st);
        chk({tag, "_vld"},   64'(m_tvalid), 64'd1);
        chk({tag, "_data"},  m_tdata, d);
        chk({tag, "_keep"},  64'(m_tkeep), 64'(k));
        chk({tag, "_last"},  64'(m_tlast), 64'(l));
        chk({tag, "_user"},  64'(m_tuser[0]), 64'(u));
        chk({tag, "_trunc"}, 64'(status_truncated), 64'(st));
    endtask

    initial begin
        rst_n      = 1'b0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tuser    = '0;
        m_tready   = 1'b1;
        length_max = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 64'(m_tvalid), 64'd0);
        chk("rst_trunc", 64'(status_truncated), 64'd0);
        rst_n = 1'b1;

        // 64-byte limit, 8 full beats: passes unchanged with one cycle of latency
        length_max = 16'd64;
        for (int i = 0; i < 8; i++) begin
            drive(64'hA000 + 64'(i), 8'hFF, i == 7);
            step();
            expect_out("full", 64'hA000 + 64'(i), 8'hFF, i == 7, 1'b0, 1'b0);
        end
        idle();
        step();
        chk("full_drain", 64'(m_tvalid), 64'd0);

        // 20-byte limit: third beat cut to 4 bytes, fourth accepted and dropped
        length_max = 16'd20;
        for (int i = 0; i < 3; i++) begin
            drive(64'hB000 + 64'(i), 8'hFF, 1'b0);
            step();
            if (i < 2) expect_out("cut20", 64'hB000 + 64'(i), 8'hFF, 1'b0, 1'b0, 1'b0);
            else       expect_out("cut20_end", 64'hB002, 8'h0F, 1'b1, 1'b1, 1'b1);
        end
        drive(64'hB003, 8'hFF, 1'b1);
        #1;
        chk("drop_rdy", 64'(s_tready), 64'd1);
        step();
        chk("drop_vld", 64'(m_tvalid), 64'd0);
        chk("drop_trunc", 64'(status_truncated), 64'd0);

        // 16-byte limit: exact-length frame, then a one-beat frame, both untouched
        length_max = 16'd16;
        drive(64'hC000, 8'hFF, 1'b0);
        step();
        expect_out("f16a", 64'hC000, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(64'hC001, 8'hFF, 1'b1);
        step();
        expect_out("f16b", 64'hC001, 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(64'hC002, 8'hFF, 1'b1);
        step();
        expect_out("f16c", 64'hC002, 8'hFF, 1'b1, 1'b0, 1'b0);
        // a zero-tkeep beat adds no bytes, so 8+0+8 still fits 16
        drive(64'hC003, 8'hFF, 1'b0);
        step();
        drive(64'hC004, 8'h00, 1'b0);
        step();
        expect_out("zk", 64'hC004, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(64'hC005, 8'hFF, 1'b1);
        step();
        expect_out("zk_end", 64'hC005, 8'hFF, 1'b1, 1'b0, 1'b0);

        // partial first beat: 4+8 > 8 cuts second beat to 4 bytes, which also ends the frame
        length_max = 16'd8;
        drive(64'hC100, 8'h0F, 1'b0);
        step();
        drive(64'hC101, 8'hFF, 1'b1);
        step();
        expect_out("part", 64'hC101, 8'h0F, 1'b1, 1'b1, 1'b1);

        // backpressure with no limit: tready pattern 1,0,0,1 then steady
        length_max = 16'd0;
        drive(64'hD000, 8'hFF, 1'b0);
        step();
        expect_out("bp0", 64'hD000, 8'hFF, 1'b0, 1'b0, 1'b0);
        m_tready = 1'b0;
        drive(64'hD001, 8'hFF, 1'b0);
        #1;
        chk("bp_rdy_lo1", 64'(s_tready), 64'd0);
        step();
        chk("bp_hold1", m_tdata, 64'hD000);
        chk("bp_hold1_vld", 64'(m_tvalid), 64'd1);
        step();
        chk("bp_hold2", m_tdata, 64'hD000);
        chk("bp_rdy_lo2", 64'(s_tready), 64'd0);
        m_tready = 1'b1;
        #1;
        chk("bp_rdy_hi", 64'(s_tready), 64'd1);
        step();
        expect_out("bp1", 64'hD001, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 5; i++) begin
            drive(64'hD000 + 64'(i), 8'hFF, i == 4);
            step();
            expect_out("bpn", 64'hD000 + 64'(i), 8'hFF, i == 4, 1'b0, 1'b0);
        end
        idle();
        step();
        chk("bp_drain", 64'(m_tvalid), 64'd0);

        // limit changed 100 -> 8 mid-frame: only the next frame sees 8
        length_max = 16'd100;
        drive(64'hE000, 8'hFF, 1'b0);
        step();
        length_max = 16'd8;
        drive(64'hE001, 8'hFF, 1'b0);
        step();
        expect_out("lim_keep", 64'hE001, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(64'hE002, 8'hFF, 1'b1);
        step();
        expect_out("lim_end", 64'hE002, 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(64'hE100, 8'hFF, 1'b0);
        step();
        expect_out("lim8_first", 64'hE100, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(64'hE101, 8'hFF, 1'b0);
        step();
        expect_out("lim8_cut", 64'hE101, 8'h00, 1'b1, 1'b1, 1'b1);
        drive(64'hE102, 8'hFF, 1'b1);
        step();
        chk("lim8_drop", 64'(m_tvalid), 64'd0);

        // reset while discarding a tail, with the cut beat still held in the output
        drive(64'hF000, 8'hFF, 1'b0);
        step();
        drive(64'hF001, 8'hFF, 1'b0);
        step();
        expect_out("rst_cut", 64'hF001, 8'h00, 1'b1, 1'b1, 1'b1);
        m_tready = 1'b0;
        drive(64'hF002, 8'hFF, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", 64'(m_tvalid), 64'd0);
        chk("rst_mid_trunc", 64'(status_truncated), 64'd0);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        length_max = 16'd16;
        drive(64'hF100, 8'hFF, 1'b0);
        step();
        expect_out("post_rst0", 64'hF100, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(64'hF101, 8'hFF, 1'b1);
        step();
        expect_out("post_rst1", 64'hF101, 8'hFF, 1'b1, 1'b0, 1'b0);
        idle();
        step();
        chk("end_drain", 64'(m_tvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
